// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO controller: I/O window, register addresses, field widths.
// The optional switch debouncer is enabled with the SW_DEBOUNCE_EN macro (see mmio_controller).
package mmio_pkg;

  localparam logic [3:0]  IO_WINDOW    = 4'hF;

  localparam logic [31:0] ADDR_HEX     = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR    = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG    = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY     = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW      = 32'hF000_0014;
  localparam logic [31:0] ADDR_KEYEDGE = 32'hF000_0018;

  localparam int HEX_W  = 16;
  localparam int LEDR_W = 10;
  localparam int LEDG_W = 8;
  localparam int KEY_W  = 4;
  localparam int SW_W   = 10;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_HEX,
    REG_LEDR,
    REG_LEDG,
    REG_KEY,
    REG_SW,
    REG_KEYEDGE
  } reg_sel_e;

  // Exact-match decode; anything else (inside or outside the window) is unmapped.
  function automatic reg_sel_e decode_addr(input logic [31:0] a);
    reg_sel_e sel;
    case (a)
      ADDR_HEX:     sel = REG_HEX;
      ADDR_LEDR:    sel = REG_LEDR;
      ADDR_LEDG:    sel = REG_LEDG;
      ADDR_KEY:     sel = REG_KEY;
      ADDR_SW:      sel = REG_SW;
      ADDR_KEYEDGE: sel = REG_KEYEDGE;
      default:      sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_sync_edge.sv
// Parameterised 2-flop synchroniser with an optional rising-edge detector on the synchronised output.
// Reset drives every flop to 0, so callers present idle inputs as 0.
module mmio_sync_edge #(
  parameter int W       = 1,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

  generate
    if (EDGE_EN) begin : g_edge
      logic [W-1:0] prev_reg;

      always_ff @(posedge clk) begin
        if (reset) prev_reg <= '0;
        else       prev_reg <= sync_reg;
      end

      for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign rise[gi] = sync_reg[gi] & ~prev_reg[gi];
      end
    end else begin : g_no_edge
      assign rise = '0;
    end
  endgenerate

endmodule

// File: rtl/mmio_controller.sv
// MMIO controller for the 0xF000_00xx window: board output registers, synchronised inputs, sticky key edges.
// Define SW_DEBOUNCE_EN to debounce the switches before they are visible on SW reads.
module mmio_controller
  import mmio_pkg::*;
#(
  parameter int DBITS = 32
`ifdef SW_DEBOUNCE_EN
  , parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DBITS-1:0]  addr,
  input  logic              wr_en,
  input  logic [DBITS-1:0]  wr_data,
  input  logic              rd_en,
  output logic              io_hit,
  output logic [DBITS-1:0]  rd_data,
  output logic              rd_valid,
  input  logic [KEY_W-1:0]  key_n,
  input  logic [SW_W-1:0]   sw,
  output logic [HEX_W-1:0]  hex_val,
  output logic [LEDR_W-1:0] ledr,
  output logic [LEDG_W-1:0] ledg
);

  logic [KEY_W-1:0]  key_s;
  logic [KEY_W-1:0]  key_rise;
  logic [SW_W-1:0]   sw_s;
  logic [SW_W-1:0]   sw_edge_unused;
  logic [SW_W-1:0]   sw_rd;
  logic              wr_data_unused;

  logic [HEX_W-1:0]  hex_reg;
  logic [LEDR_W-1:0] ledr_reg;
  logic [LEDG_W-1:0] ledg_reg;
  logic [KEY_W-1:0]  keyedge_reg;
  logic [KEY_W-1:0]  keyedge_clr;
  logic [DBITS-1:0]  rd_data_reg;
  logic              rd_valid_reg;
  logic [DBITS-1:0]  rd_mux;
  reg_sel_e          sel;

  // Keys are inverted up front so that "pressed" is 1 and the reset state means "not pressed".
  mmio_sync_edge #(.W(KEY_W), .EDGE_EN(1'b1)) u_key_sync (
    .clk   (clk),
    .reset (reset),
    .d     (~key_n),
    .q     (key_s),
    .rise  (key_rise)
  );

  mmio_sync_edge #(.W(SW_W), .EDGE_EN(1'b0)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (sw_s),
    .rise  (sw_edge_unused)
  );

`ifdef SW_DEBOUNCE_EN
  logic [15:0]     db_cnt_reg;
  logic [SW_W-1:0] db_cand_reg;
  logic [SW_W-1:0] sw_db_reg;

  // Any change restarts the window; the candidate is published once it has held long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_reg  <= '0;
      db_cand_reg <= '0;
      sw_db_reg   <= '0;
    end else if (sw_s != db_cand_reg) begin
      db_cand_reg <= sw_s;
      db_cnt_reg  <= '0;
    end else if (db_cnt_reg == DEBOUNCE_CYCLES - 16'd1) begin
      sw_db_reg   <= db_cand_reg;
    end else begin
      db_cnt_reg  <= db_cnt_reg + 16'd1;
    end
  end

  assign sw_rd = sw_db_reg;
`else
  assign sw_rd = sw_s;
`endif

  assign sel            = decode_addr(addr);
  assign io_hit         = (addr[DBITS-1 -: 4] == IO_WINDOW);
  assign wr_data_unused = ^wr_data[DBITS-1:HEX_W];
  assign keyedge_clr    = (wr_en && sel == REG_KEYEDGE) ? wr_data[KEY_W-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_HEX:     rd_mux[HEX_W-1:0]  = hex_reg;
      REG_LEDR:    rd_mux[LEDR_W-1:0] = ledr_reg;
      REG_LEDG:    rd_mux[LEDG_W-1:0] = ledg_reg;
      REG_KEY:     rd_mux[KEY_W-1:0]  = key_s;
      REG_SW:      rd_mux[SW_W-1:0]   = sw_rd;
      REG_KEYEDGE: rd_mux[KEY_W-1:0]  = keyedge_reg;
      default:     rd_mux             = '0;
    endcase
  end

  // The read mux samples register state before this edge's write, so a same-cycle read sees the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_reg      <= '0;
      ledr_reg     <= '0;
      ledg_reg     <= '0;
      keyedge_reg  <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        case (sel)
          REG_HEX:  hex_reg  <= wr_data[HEX_W-1:0];
          REG_LEDR: ledr_reg <= wr_data[LEDR_W-1:0];
          REG_LEDG: ledg_reg <= wr_data[LEDG_W-1:0];
          default:  ;
        endcase
      end
      // A fresh press beats a software clear of the same bit.
      keyedge_reg  <= (keyedge_reg & ~keyedge_clr) | key_rise;
      rd_valid_reg <= rd_en;
      if (rd_en) rd_data_reg <= rd_mux;
    end
  end

  assign hex_val  = hex_reg;
  assign ledr     = ledr_reg;
  assign ledg     = ledg_reg;
  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_mmio_controller.sv
// Scoreboard bench for mmio_controller: a history-based reference model predicts reads and register outputs.
// Covers the default build (switches visible after plain 2-cycle synchronisation).
module tb_mmio_controller;

  localparam logic [31:0] A_HEX     = 32'hF000_0000;
  localparam logic [31:0] A_LEDR    = 32'hF000_0004;
  localparam logic [31:0] A_LEDG    = 32'hF000_0008;
  localparam logic [31:0] A_KEY     = 32'hF000_0010;
  localparam logic [31:0] A_SW      = 32'hF000_0014;
  localparam logic [31:0] A_KEYEDGE = 32'hF000_0018;
  localparam int          HIST      = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic        io_hit;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [15:0] hex_val;
  logic [9:0]  ledr;
  logic [7:0]  ledg;

  always #5 clk = ~clk;

  mmio_controller dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .io_hit   (io_hit),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .key_n    (key_n),
    .sw       (sw),
    .hex_val  (hex_val),
    .ledr     (ledr),
    .ledg     (ledg)
  );

  // Reference model: architectural register values plus the history of sampled board inputs.
  // A sampled input becomes visible two edges later; an edge is "pressed now, not pressed one sample earlier".
  logic [15:0] m_hex;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;
  logic [3:0]  m_ke;
  logic [31:0] m_rd;
  logic        m_rv;
  logic [3:0]  key_hist [0:HIST-1];
  logic [9:0]  sw_hist  [0:HIST-1];
  int          cyc;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [3:0] ks,
                                             input logic [9:0] sws);
    case (a)
      A_HEX:     return {16'h0, m_hex};
      A_LEDR:    return {22'h0, m_ledr};
      A_LEDG:    return {24'h0, m_ledg};
      A_KEY:     return {28'h0, ks};
      A_SW:      return {22'h0, sws};
      A_KEYEDGE: return {28'h0, m_ke};
      default:   return 32'h0;
    endcase
  endfunction

  // One clock: predict from pre-edge state, wait for the edge, commit, then move inputs off the edge.
  task automatic step();
    logic [3:0]  ks, kp, rise;
    logic [9:0]  sws;
    logic [15:0] n_hex;
    logic [9:0]  n_ledr;
    logic [7:0]  n_ledg;
    logic [3:0]  n_ke;
    logic [31:0] n_rd;
    logic        n_rv;
    ks     = key_hist[cyc-2];
    kp     = key_hist[cyc-3];
    sws    = sw_hist[cyc-2];
    rise   = ks & ~kp;
    n_hex  = m_hex;
    n_ledr = m_ledr;
    n_ledg = m_ledg;
    n_ke   = m_ke | rise;
    n_rd   = m_rd;
    n_rv   = 1'b0;
    if (reset) begin
      n_hex = '0; n_ledr = '0; n_ledg = '0; n_ke = '0; n_rd = '0;
      key_hist[cyc] = '0; key_hist[cyc-1] = '0;
      sw_hist[cyc]  = '0; sw_hist[cyc-1]  = '0;
    end else begin
      key_hist[cyc] = ~key_n;
      sw_hist[cyc]  = sw;
      if (rd_en) begin
        n_rd = model_read(addr, ks, sws);
        n_rv = 1'b1;
        exp_q.push_back('{addr, n_rd});
      end
      if (wr_en) begin
        case (addr)
          A_HEX:     n_hex  = wr_data[15:0];
          A_LEDR:    n_ledr = wr_data[9:0];
          A_LEDG:    n_ledg = wr_data[7:0];
          A_KEYEDGE: n_ke   = (m_ke & ~wr_data[3:0]) | rise;
          default:   ;
        endcase
      end
    end
    @(posedge clk);
    m_hex = n_hex; m_ledr = n_ledr; m_ledg = n_ledg; m_ke = n_ke;
    m_rd = n_rd; m_rv = n_rv;
    cyc++;
    mon_on = 1'b1;
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0; wr_en = 1'b0; addr = 32'h0; wr_data = 32'h0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    step();
    idle();
  endtask

  task automatic do_read(input logic [31:0] a);
    rd_en = 1'b1; addr = a;
    step();
    idle();
  endtask

  // Monitor: per-cycle output checks plus scoreboard pops whenever the DUT presents read data.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("io_hit", {31'h0, io_hit}, {31'h0, addr[31:28] == 4'hF});
      chk("hex_val", {16'h0, hex_val}, {16'h0, m_hex});
      chk("ledr", {22'h0, ledr}, {22'h0, m_ledr});
      chk("ledg", {24'h0, ledg}, {24'h0, m_ledg});
      chk("rd_valid", {31'h0, rd_valid}, {31'h0, m_rv});
      chk("rd_data_hold", rd_data, m_rd);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_valid_unexpected", 32'h1, 32'h0);
        end else begin
          rd_exp_t e;
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e.d);
          $display("read addr=%h data=%h expected=%h", e.a, rd_data, e.d);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addr_tab [0:9];
    addr_tab[0] = A_HEX;  addr_tab[1] = A_LEDR; addr_tab[2] = A_LEDG;
    addr_tab[3] = A_KEY;  addr_tab[4] = A_SW;   addr_tab[5] = A_KEYEDGE;
    addr_tab[6] = 32'hF000_0020; addr_tab[7] = 32'h0000_0010;
    addr_tab[8] = 32'hF000_000C; addr_tab[9] = 32'hE000_0000;

    for (int i = 0; i < HIST; i++) begin
      key_hist[i] = '0;
      sw_hist[i]  = '0;
    end
    cyc = 3;
    m_hex = '0; m_ledr = '0; m_ledg = '0; m_ke = '0; m_rd = '0; m_rv = 1'b0;

    reset = 1'b1; key_n = 4'hF; sw = '0;
    idle();
    repeat (3) step();
    reset = 1'b0;

    // Reset state, then HEX write/readback.
    do_read(A_KEYEDGE);
    do_read(A_HEX);
    do_write(A_HEX, 32'h0000_ABCD);
    do_read(A_HEX);

    // Key 0 held: KEY and sticky KEYEDGE, release, then write-1-to-clear.
    key_n = 4'b1110;
    repeat (4) do_read(A_KEY);
    do_read(A_KEYEDGE);
    key_n = 4'hF;
    repeat (3) step();
    do_read(A_KEYEDGE);
    do_write(A_KEYEDGE, 32'h1);
    do_read(A_KEYEDGE);
    do_read(A_KEY);

    // New press reaches the edge detector on the same edge as a clear: set wins.
    key_n = 4'b1110;
    step();
    step();
    do_write(A_KEYEDGE, 32'h1);
    do_read(A_KEYEDGE);
    key_n = 4'hF;

    // Same-cycle read and write of LEDR returns the old value.
    rd_en = 1'b1; wr_en = 1'b1; addr = A_LEDR; wr_data = 32'h0000_03FF;
    step();
    idle();
    do_read(A_LEDR);
    do_write(A_LEDG, 32'hFFFF_FFA5);
    do_read(A_LEDG);

    // Unmapped reads inside and outside the window; writes to read-only addresses.
    do_read(32'hF000_0020);
    do_read(32'h0000_0010);
    do_write(A_KEY, 32'hF);
    do_write(A_SW, 32'h3FF);
    do_read(A_KEY);

    sw = 10'h155;
    repeat (3) step();
    do_read(A_SW);

    // Reset asserted alongside a read: the read is dropped.
    rd_en = 1'b1; addr = A_HEX; reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    step();
    do_read(A_HEX);

    for (int i = 0; i < 600; i++) begin
      addr    = addr_tab[$urandom_range(0, 9)];
      wr_en   = ($urandom_range(0, 2) == 0);
      rd_en   = ($urandom_range(0, 1) == 1);
      wr_data = $urandom;
      if ($urandom_range(0, 3) == 0) key_n = 4'($urandom);
      if ($urandom_range(0, 3) == 0) sw = 10'($urandom);
      reset   = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    repeat (3) step();

    chk("queue_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_controller.md
Name: mmio_controller

Overview:
- Memory-mapped I/O controller for the single-cycle processor's data path.
- Sits beside data memory on the data bus: decodes bus addresses in the 0xF000_00xx I/O window, owns the board output registers (HEX, LEDR, LEDG), and synchronises board inputs (KEY, SW).
- Returns registered read data and raises an I/O-hit flag so the top level steers read data away from data memory.

Parameters:
- DBITS, 32, data/address bus width
- ADDR_HEX, 32'hF0000000, HEX display register (16 bit, 4 nibbles)
- ADDR_LEDR, 32'hF0000004, red LED register (10 bit)
- ADDR_LEDG, 32'hF0000008, green LED register (8 bit)
- ADDR_KEY, 32'hF0000010, current key state, read-only
- ADDR_SW, 32'hF0000014, current switch state, read-only
- ADDR_KEYEDGE, 32'hF0000018, sticky key-press flags, write-1-to-clear
- DEBOUNCE_CYCLES, 16'd50000, switch stability window (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  DBITS  bus address
- wr_en  in  1  bus write strobe
- wr_data  in  DBITS  bus write data
- rd_en  in  1  bus read strobe
- io_hit  out  1  combinational: addr[31:28]==4'hF
- rd_data  out  DBITS  registered read data
- rd_valid  out  1  rd_data valid this cycle
- key_n  in  4  raw board keys, active-low, asynchronous
- sw  in  10  raw board switches, asynchronous
- hex_val  out  16  value for the external seven-segment decoders
- ledr  out  10  red LEDs
- ledg  out  8  green LEDs

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - hex_val, ledr, ledg, rd_data, rd_valid, and the key-edge register all reset to 0.
  - Synchroniser flops reset to the idle state: keys not pressed, switches 0.
- Input synchronisation:
  - key_n is inverted (pressed=1) and passed through 2 flops to give key_s.
  - sw passes through 2 flops to give sw_s.
  - An input change is visible at the register interface 2 cycles after it is sampled.
- Key edge detection:
  - A third flop holds the previous key_s.
  - keyedge[i] is set on a cycle where key_s[i]=1 and prev[i]=0.
  - keyedge bits stay set until cleared by software.
- Writes take effect at the clock edge when wr_en=1 and addr matches exactly:
  - HEX: hex_val <= wr_data[15:0]
  - LEDR: ledr <= wr_data[9:0]
  - LEDG: ledg <= wr_data[7:0]
  - KEYEDGE: clears each bit whose wr_data bit [3:0] is 1.
  - Writes to KEY, SW, or unmapped I/O addresses are ignored.
- Reads:
  - When rd_en=1, rd_data is loaded at the next edge and rd_valid=1 for exactly that one cycle (1-cycle latency).
  - Returned values are zero-extended:
    - HEX returns {16'b0, hex_val}.
    - LEDR, LEDG return their register value.
    - KEY returns key_s.
    - SW returns sw_s.
    - KEYEDGE returns keyedge.
    - Unmapped addresses, including those outside the I/O window, return 0.
  - If rd_en=0, rd_data holds its value and rd_valid=0.
- Simultaneous events:
  - Read and write to the same address in one cycle: the read returns the pre-write value.
  - keyedge set and software clear of the same bit in one cycle: set wins, bit stays 1.
  - Reading KEYEDGE never clears it.
- Reset mid-operation: any pending read is dropped; rd_valid=0 on the cycle after reset is asserted.
- No back-pressure: the block accepts one access per cycle.

Optional Feature:
- Macro SW_DEBOUNCE_EN.
- When defined:
  - A 16-bit counter per block (shared) restarts whenever sw_s differs from the candidate register.
  - sw_db is updated from the candidate only after DEBOUNCE_CYCLES consecutive cycles of stability.
  - SW reads return sw_db.
  - Counter, candidate, and sw_db reset to 0.
- When undefined: SW reads return sw_s directly; no counter logic is present.

Decomposition:
- Shared package mmio_pkg holds the address constants (ADDR_*), the I/O window nibble 4'hF, and the register field widths.
- One natural sub-module: mmio_sync_edge, a parameterised-width 2-flop synchroniser with an optional rising-edge output. It is instantiated for keys (edge used) and switches (edge unused).

Test Plan:
- Reset, then write 0x0000ABCD to ADDR_HEX and read it back -> hex_val=16'hABCD; rd_data=0x0000ABCD exactly 1 cycle after rd_en, rd_valid pulses once.
- Hold key_n=4'b1110 from cycle 0 -> KEY read returns 0x1 from cycle 2 onward; KEYEDGE=0x1. Release the key -> KEYEDGE stays 0x1. Write 0x1 to KEYEDGE -> reads 0x0.
- A new press on key 0 lands on the same cycle as a KEYEDGE write of 0x1 -> bit 0 reads 1 afterwards (set wins).
- Write 0x3FF to LEDR while reading LEDR in the same cycle -> rd_data=0x0 (old value); ledr=10'h3FF on the next cycle.
- Read 0xF0000020 and 0x00000010 -> rd_data=0 for both; io_hit=1 for the first address, 0 for the second.
- With SW_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: toggle sw every 2 cycles -> SW read stays 0. Hold sw=10'h155 -> SW reads 0x155 after 2 sync cycles plus the 4-cycle stability window.
